// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, FSM state type and opcode-class helpers shared by the
// sequential multiply/divide unit and its bench.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic op_is_mul(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: (W+1)-bit adder/subtractor with carry-out, shared by the multiply
// accumulate and the restoring-divide trial subtraction.
module mdu_addsub #(
  parameter int W = 32
) (
  input  logic [W:0] x_i,
  input  logic [W:0] y_i,
  input  logic       sub_i,
  output logic [W:0] sum_o,
  output logic       carry_o
);

  logic [W+1:0] full_s;

  // Subtraction as x + ~y + 1, so carry_o=1 means x >= y.
  assign full_s  = {1'b0, x_i} + {1'b0, (sub_i ? ~y_i : y_i)} + {{(W+1){1'b0}}, sub_i};
  assign sum_o   = full_s[W:0];
  assign carry_o = full_s[W+1];

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU (one bit per cycle) with architectural HI/LO.
// The divider datapath is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU are illegal.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, mc_q, mc_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           done_q, done_d, err_q, err_d;
`ifdef MDU_DIV_EN
  logic           rneg_q, rneg_d;
`endif

  logic           accept_s;
  logic [W-1:0]   abs_a_s, abs_b_s, work_hi_s, work_lo_s;
  logic [W:0]     add_x_s, add_y_s, add_sum_s;
  logic           add_sub_s, add_carry_s;
  logic [2*W-1:0] mul_step_s, mul_fix_s;

  function automatic logic starts_iter(input logic [2:0] o);
`ifdef MDU_DIV_EN
    return op_is_mul(o) || op_is_div(o);
`else
    return op_is_mul(o);
`endif
  endfunction

  assign accept_s  = in_valid && (state_q == IDLE) && !flush;
  assign work_hi_s = work_q[2*W-1:W];
  assign work_lo_s = work_q[W-1:0];
  assign abs_a_s   = (op_is_signed(op_q) && a_q[W-1]) ? -a_q : a_q;
  assign abs_b_s   = (op_is_signed(op_q) && b_q[W-1]) ? -b_q : b_q;

  // Divide feeds the shifted partial remainder; multiply feeds the high product half.
`ifdef MDU_DIV_EN
  assign add_sub_s = op_is_div(op_q);
  assign add_x_s   = add_sub_s ? {work_hi_s, work_lo_s[W-1]} : {1'b0, work_hi_s};
`else
  assign add_sub_s = 1'b0;
  assign add_x_s   = {1'b0, work_hi_s};
`endif
  assign add_y_s   = {1'b0, mc_q};

  mdu_addsub #(.W(W)) u_addsub (
    .x_i     (add_x_s),
    .y_i     (add_y_s),
    .sub_i   (add_sub_s),
    .sum_o   (add_sum_s),
    .carry_o (add_carry_s)
  );

  // Carry-out is always zero for the zero-extended multiply add; OR-ing it is harmless.
  assign mul_step_s = work_lo_s[0]
                    ? {add_carry_s | add_sum_s[W], add_sum_s[W-1:0], work_lo_s[W-1:1]}
                    : {1'b0, work_q[2*W-1:1]};
  assign mul_fix_s  = neg_q ? ({(2*W){1'b0}} - work_q) : work_q;

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mc_d    = mc_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MDU_DIV_EN
    rneg_d  = rneg_q;
`endif
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_d = op;
            a_d  = a;
            b_d  = b;
            if (starts_iter(op)) begin
              state_d = PREP;
            end else begin
              state_d = RESP;
              done_d  = 1'b1;
              if (op == OP_MTHI) begin
                hi_d = a;
              end else if (op == OP_MTLO) begin
                lo_d = a;
              end else begin
                err_d = 1'b1;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
        PREP: begin
          state_d = ITER;
          cnt_d   = CNT_LOAD;
          neg_d   = op_is_signed(op_q) && (a_q[W-1] ^ b_q[W-1]);
`ifdef MDU_DIV_EN
          rneg_d  = op_is_signed(op_q) && a_q[W-1];
          if (op_is_div(op_q)) begin
            mc_d   = abs_b_s;
            work_d = {{W{1'b0}}, abs_a_s};
          end else begin
            mc_d   = abs_a_s;
            work_d = {{W{1'b0}}, abs_b_s};
          end
`else
          mc_d    = abs_a_s;
          work_d  = {{W{1'b0}}, abs_b_s};
`endif
        end
        ITER: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIX;
          end else begin
            state_d = ITER;
          end
`ifdef MDU_DIV_EN
          if (op_is_div(op_q)) begin
            if (add_carry_s) begin
              work_d = {add_sum_s[W-1:0], work_lo_s[W-2:0], 1'b1};
            end else begin
              work_d = {work_q[2*W-2:0], 1'b0};
            end
          end else begin
            work_d = mul_step_s;
          end
`else
          work_d = mul_step_s;
`endif
        end
        FIX: begin
          state_d = RESP;
          done_d  = 1'b1;
`ifdef MDU_DIV_EN
          if (op_is_div(op_q)) begin
            if (b_q == {W{1'b0}}) begin
              lo_d  = {W{1'b1}};
              hi_d  = a_q;
              err_d = 1'b1;
            end else begin
              lo_d = neg_q ? -work_lo_s : work_lo_s;
              hi_d = rneg_q ? -work_hi_s : work_hi_s;
            end
          end else begin
            {hi_d, lo_d} = mul_fix_s;
          end
`else
          {hi_d, lo_d} = mul_fix_s;
`endif
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      mc_q    <= {W{1'b0}};
      work_q  <= {(2*W){1'b0}};
      cnt_q   <= {CW{1'b0}};
      neg_q   <= 1'b0;
      hi_q    <= {W{1'b0}};
      lo_q    <= {W{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mc_q    <= mc_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MDU_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq (W=32); expectations for DIV/DIVU
// follow whether MDU_DIV_EN is defined for the build.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Issue one op from IDLE at a negedge; report the cycle of done (-1 if none) and HI/LO then.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int dcyc, output logic derr,
                        output logic [31:0] dhi, output logic [31:0] dlo);
    dcyc = -1; derr = 1'b0; dhi = 32'h0; dlo = 32'h0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (done === 1'b1) begin
        dcyc = i; derr = err; dhi = hi; dlo = lo;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_move();
    int dc; logic de; logic [31:0] dh, dl;
    run_op(OP_MTHI, 32'h0000_1234, 32'h0, dc, de, dh, dl);
    checks++; if (dc !== 1) begin errors++; $display("FAIL mthi_done_cycle: got %0d expected 1", dc); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL mthi_err: got %b expected 0", de); end
    checks++; if (dh !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi: got %h expected %h", dh, 32'h0000_1234); end
    run_op(OP_MTLO, 32'hCAFE_0001, 32'h0, dc, de, dh, dl);
    checks++; if (dl !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", dl, 32'hCAFE_0001); end
    checks++; if (dh !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected %h", dh, 32'h0000_1234); end
  endtask

  task automatic test_mul();
    int dc; logic de; logic [31:0] dh, dl;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, dc, de, dh, dl);
    checks++; if (dc !== 35) begin errors++; $display("FAIL mult_done_cycle: got %0d expected 35", dc); end
    checks++; if (dh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected %h", dh, 32'hFFFF_FFFF); end
    checks++; if (dl !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected %h", dl, 32'hFFFF_FFF1); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL mult_err: got %b expected 0", de); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, de, dh, dl);
    checks++; if (dh !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi: got %h expected %h", dh, 32'hFFFF_FFFE); end
    checks++; if (dl !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo: got %h expected %h", dl, 32'h0000_0001); end
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, dc, de, dh, dl);
    checks++; if ({dh, dl} !== 64'h0000_0000_0000_0006) begin errors++; $display("FAIL mult_negneg: got %h expected %h", {dh, dl}, 64'h6); end
    run_op(OP_MULTU, 32'h8000_0000, 32'h0000_0004, dc, de, dh, dl);
    checks++; if ({dh, dl} !== 64'h0000_0002_0000_0000) begin errors++; $display("FAIL multu_carry: got %h expected %h", {dh, dl}, 64'h2_0000_0000); end
  endtask

  task automatic test_div();
    int dc; logic de; logic [31:0] dh, dl;
`ifdef MDU_DIV_EN
    run_op(OP_DIVU, 32'd100, 32'd7, dc, de, dh, dl);
    checks++; if (dc !== 35) begin errors++; $display("FAIL divu_done_cycle: got %0d expected 35", dc); end
    checks++; if (dl !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo: got %h expected %h", dl, 32'hE); end
    checks++; if (dh !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi: got %h expected %h", dh, 32'h2); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, dc, de, dh, dl);
    checks++; if (dl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", dl, 32'hFFFF_FFFD); end
    checks++; if (dh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", dh, 32'hFFFF_FFFF); end
    run_op(OP_DIV, 32'h0000_0005, 32'h0000_0000, dc, de, dh, dl);
    checks++; if (dl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected %h", dl, 32'hFFFF_FFFF); end
    checks++; if (dh !== 32'h0000_0005) begin errors++; $display("FAIL div0_hi: got %h expected %h", dh, 32'h5); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL div0_err: got %b expected 1", de); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, de, dh, dl);
    checks++; if (dl !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", dl, 32'h8000_0000); end
    checks++; if (dh !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi: got %h expected %h", dh, 32'h0); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL divovf_err: got %b expected 0", de); end
`else
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    run_op(OP_DIVU, 32'd100, 32'd7, dc, de, dh, dl);
    checks++; if (dc !== 1) begin errors++; $display("FAIL divu_nodiv_cycle: got %0d expected 1", dc); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL divu_nodiv_err: got %b expected 1", de); end
    checks++; if ({dh, dl} !== {hi0, lo0}) begin errors++; $display("FAIL divu_nodiv_hilo: got %h expected %h", {dh, dl}, {hi0, lo0}); end
`endif
  endtask

  task automatic test_illegal();
    int dc; logic de; logic [31:0] dh, dl;
    run_op(OP_MTHI, 32'h0000_0A0A, 32'h0, dc, de, dh, dl);
    run_op(OP_MTLO, 32'h0000_0B0B, 32'h0, dc, de, dh, dl);
    run_op(3'd7, 32'h5555_5555, 32'h1, dc, de, dh, dl);
    checks++; if (dc !== 1) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 1", dc); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", de); end
    checks++; if ({dh, dl} !== 64'h0000_0A0A_0000_0B0B) begin errors++; $display("FAIL illegal_hilo: got %h expected %h", {dh, dl}, 64'h0000_0A0A_0000_0B0B); end
  endtask

  task automatic test_flush();
    int dc; logic de; logic [31:0] dh, dl;
    int seen_done; int ready_bad;
    run_op(OP_MTHI, 32'h0000_1234, 32'h0, dc, de, dh, dl);
    run_op(OP_MTLO, 32'h0000_0077, 32'h0, dc, de, dh, dl);
    seen_done = 0; ready_bad = 0;
    op = OP_MULT; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) begin op = OP_MTLO; a = 32'h0000_DEAD; end
      if (done === 1'b1) seen_done++;
      if (in_ready !== 1'b0) ready_bad++;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_c11: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_c11: got %b expected 0", busy); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL flush_ready_while_busy: got %0d cycles ready expected 0", ready_bad); end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen_done); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL flush_hi: got %h expected %h", hi, 32'h0000_1234); end
    checks++; if (lo !== 32'h0000_0077) begin errors++; $display("FAIL flush_held_valid_lo: got %h expected %h", lo, 32'h0000_0077); end
  endtask

  task automatic test_reset_mid();
    int dc; logic de; logic [31:0] dh, dl;
    run_op(OP_MTLO, 32'h0000_0055, 32'h0, dc, de, dh, dl);
    op = OP_MULTU; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h expected %h", {hi, lo}, 64'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d1; int d2; logic [31:0] l1, l2, h2;
    d1 = -1; d2 = -1; l1 = 32'h0; l2 = 32'h0; h2 = 32'h0;
    op = OP_MULTU; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = c; l1 = lo;
        end else begin
          d2 = c; l2 = lo; h2 = hi; in_valid = 1'b0;
          break;
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (d1 !== 35) begin errors++; $display("FAIL b2b_first_done: got %0d expected 35", d1); end
    checks++; if (d2 !== 71) begin errors++; $display("FAIL b2b_second_done: got %0d expected 71", d2); end
    checks++; if (l1 !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", l1, 32'd42); end
    checks++; if ({h2, l2} !== 64'd42) begin errors++; $display("FAIL b2b_second_prod: got %h expected %h", {h2, l2}, 64'd42); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_mul();
    test_div();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised sequential multiply/divide unit sitting beside the combinational ALU in the execute stage. It executes MIPS-style MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and holds results in architectural HI/LO registers; MTHI/MTLO write those registers directly. The pipeline stalls on `busy` and reads `hi`/`lo` combinationally for MFHI/MFLO.

## Interface
- `W`, 32: operand and result width; even, >= 4.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  3  opcode (package constants).
- `a`  in  W  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- `b`  in  W  rt operand: divisor or multiplier.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; HI/LO are valid this cycle.
- `err`  out  1  qualified by `done`: divide-by-zero or illegal op.
- `hi`  out  W  HI register.
- `lo`  out  W  LO register.

## Operation
- Opcodes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are illegal.
- Accept when `in_valid && in_ready && !flush`. Latch `op`, `a` and `b`.
- States and transitions:
  - IDLE to PREP for MULT/MULTU/DIV/DIVU.
  - IDLE to RESP for MTHI/MTLO/illegal.
  - PREP: take absolute values for signed ops and record the result signs. Load counter = W.
  - ITER: shift-add multiply or restoring divide, one bit per cycle. Counter decrements. Leave when counter reaches 0, to FIX.
  - FIX: apply two's-complement sign correction and write HI/LO. Go to RESP.
  - RESP: `done`=1, then IDLE.
- MTHI/MTLO: write `hi` or `lo` on the accept edge. `done` pulses in RESP, `err`=0.
- Multiply result: full 2W-bit product, HI = upper W bits, LO = lower W bits.
- Divide result: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide-by-zero: LO = all ones, HI = `a`, `err`=1.
- Signed overflow (MIN_INT / -1): LO = MIN_INT, HI = 0, `err`=0.
- Illegal op: HI/LO unchanged, `err`=1.
- `flush` in any non-IDLE state: next state IDLE, HI/LO unchanged, no `done`. `flush` in IDLE blocks acceptance.
- `in_valid` while busy is ignored; the requester holds its request.
- Reset: state IDLE; `hi`, `lo`, `done`, `err`, `busy` = 0; `in_ready`=1 in the cycle after reset.
- Reset mid-operation behaves like flush, but also clears HI/LO.

## Timing
- Accept at edge 0.
- MUL/DIV: PREP at cycle 1, ITER at cycles 2..W+1, FIX at W+2, RESP at W+3. `done` is high in cycle W+3 (35 for W=32).
- HI/LO update on the FIX-to-RESP edge.
- MTHI/MTLO/illegal: `done` in cycle 1.
- `in_ready` returns high in the cycle after RESP. Back-to-back throughput is one op per W+4 cycles.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `MDU_DIV_EN` undefined:
  - No divider datapath is built.
  - DIV/DIVU decode as illegal: `done` in cycle 1 with `err`=1, HI/LO unchanged.
  - Multiply and move ops are unaffected.

## Structure
- Package `mdu_pkg`: opcode localparams, the state enum (IDLE, PREP, ITER, FIX, RESP), and `W`-independent helper constants.
- Sub-module `mdu_addsub`: (W+1)-bit add/subtract with carry-out, shared by the multiply accumulate and the divide trial-subtract.
- Top: FSM, counter of $clog2(W)+1 bits, the 2W-bit working register, sign-fix logic, and the HI/LO registers.

## Test plan
- MULT a=-3, b=5 -> `done` at cycle 35; hi=FFFFFFFF, lo=FFFFFFF1, `err`=0.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 -> lo=0000000E, hi=00000002. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 5/0 -> lo=FFFFFFFF, hi=00000005, `err`=1. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0, `err`=0.
- MTHI 1234 then MULT with `flush` at cycle 10:
  - no `done` from the MULT, hi=00001234;
  - `in_ready`=1 in cycle 11;
  - `in_valid` held during busy is not accepted.
- `rst_n` low during ITER -> next cycle IDLE, hi=lo=0. Without `MDU_DIV_EN`: DIVU -> `done` in cycle 1 with `err`=1.
